// File: rtl/ysyx_220066_store_buf_if.sv
// rtl/ysyx_220066_store_buf_if.sv - store request, load probe and memory-write port bundle
interface ysyx_220066_store_buf_if;
    logic        MemWr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  MemOp;
    logic        ready;
    logic        error;
    logic        empty;
    logic        ld_en;
    logic [63:0] ld_addr;
    logic        ld_conflict;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_mask;
    logic        mem_ack;

    modport master (
        output MemWr, addr, wdata, MemOp, ld_en, ld_addr, mem_ack,
        input  ready, error, empty, ld_conflict, mem_valid, mem_addr, mem_data, mem_mask
    );

    modport slave (
        input  MemWr, addr, wdata, MemOp, ld_en, ld_addr, mem_ack,
        output ready, error, empty, ld_conflict, mem_valid, mem_addr, mem_data, mem_mask
    );
endinterface

// File: rtl/ysyx_220066_store_buf.sv
// rtl/ysyx_220066_store_buf.sv - in-order store buffer with lane alignment and load-hit detection
module ysyx_220066_store_buf #(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_220066_store_buf_if.slave sb
);
    localparam int              PW   = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [60:0]      waddr_q [DEPTH];
    logic [63:0]      data_q  [DEPTH];
    logic [7:0]       mask_q  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             error_q, error_d;

    logic        aligned, ready_w, nonempty_w, do_enq, do_pop, ld_hit;
    logic [7:0]  base_mask, in_mask;
    logic [63:0] in_data;
    logic        unused_ok;

    always_comb begin
        aligned   = 1'b1;
        base_mask = 8'h01;
        case (sb.MemOp[1:0])
            2'b00: begin aligned = 1'b1;              base_mask = 8'h01; end
            2'b01: begin aligned = ~sb.addr[0];       base_mask = 8'h03; end
            2'b10: begin aligned = ~|sb.addr[1:0];    base_mask = 8'h0F; end
            default: begin aligned = ~|sb.addr[2:0];  base_mask = 8'hFF; end
        endcase
    end

    assign in_mask = base_mask << sb.addr[2:0];
    assign in_data = sb.wdata << {sb.addr[2:0], 3'b000};

    assign ready_w    = (count_q != FULL);
    assign nonempty_w = (count_q != '0);
    assign do_enq     = sb.MemWr & ready_w & aligned;
    assign do_pop     = sb.mem_ack & nonempty_w;
    assign error_d    = sb.MemWr & ready_w & ~aligned;

    always_comb begin
        head_d  = do_pop ? head_q + PW'(1) : head_q;
        tail_d  = do_enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({do_enq, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        valid_d = valid_q;
        if (do_pop) valid_d[head_q] = 1'b0;
        if (do_enq) valid_d[tail_q] = 1'b1;
    end

    // Only resident entries are probed; the head stays visible until its pop lands.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == sb.ld_addr[63:3])) ld_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            waddr_q[tail_q] <= sb.addr[63:3];
            data_q[tail_q]  <= in_data;
            mask_q[tail_q]  <= in_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign sb.ready       = ready_w;
    assign sb.empty       = ~nonempty_w;
    assign sb.error       = error_q;
    assign sb.ld_conflict = sb.ld_en & ld_hit;
    assign sb.mem_valid   = nonempty_w;
    assign sb.mem_addr    = {waddr_q[head_q], 3'b000};
    assign sb.mem_data    = data_q[head_q];
    assign sb.mem_mask    = mask_q[head_q];

    assign unused_ok = &{1'b0, sb.MemOp[2], sb.ld_addr[2:0]};
endmodule

// File: tb/tb_ysyx_220066_store_buf.sv
// tb/tb_ysyx_220066_store_buf.sv - scoreboard bench for the store buffer
module tb_ysyx_220066_store_buf;
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    ysyx_220066_store_buf_if bus ();

    ysyx_220066_store_buf #(.DEPTH(4), .CNTW(3)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] byte_en(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op);
        bus.MemWr = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        bus.MemOp = op;
    endtask

    task automatic expect_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.mask = m;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted memory write must match the oldest expected store.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.mem_valid && bus.mem_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: addr %h data %h mask %h with nothing expected",
                             bus.mem_addr, bus.mem_data, bus.mem_mask);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_addr", bus.mem_addr, e.addr);
                    chk("pop_mask", {56'd0, bus.mem_mask}, {56'd0, e.mask});
                    chk("pop_data", bus.mem_data & byte_en(e.mask), e.data & byte_en(e.mask));
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.MemWr   = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.MemOp   = '0;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.mem_ack = 1'b0;
        step;
        step;
        rst = 1'b0;
        #2;
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 64'h8000_0000;
        #1;
        chk("rst_ldc", 64'(bus.ld_conflict), 64'd0);
        bus.ld_en = 1'b0;

        // sb into byte 5 of the word
        step;
        issue(64'h8000_0005, 64'hAB, 3'b000);
        expect_store(64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20);
        step;
        bus.MemWr = 1'b0;
        #2;
        chk("sb_valid", 64'(bus.mem_valid), 64'd1);
        chk("sb_empty", 64'(bus.empty), 64'd0);
        chk("sb_error", 64'(bus.error), 64'd0);
        bus.mem_ack = 1'b1;
        step;
        bus.mem_ack = 1'b0;
        #2;
        chk("sb_drained", 64'(bus.empty), 64'd1);

        // misaligned sw
        issue(64'h8000_0006, 64'hDEAD_BEEF, 3'b010);
        step;
        bus.MemWr = 1'b0;
        #2;
        chk("mis_error", 64'(bus.error), 64'd1);
        chk("mis_empty", 64'(bus.empty), 64'd1);
        chk("mis_valid", 64'(bus.mem_valid), 64'd0);
        step;
        #2;
        chk("mis_error_clr", 64'(bus.error), 64'd0);

        // fill with sd, extra store ignored, then drain in order
        for (int i = 0; i < 4; i++) begin
            issue(64'h8000_1000 + 64'(8 * i), 64'h0123_4567_89AB_CD00 | 64'(i), 3'b011);
            expect_store(64'h8000_1000 + 64'(8 * i), 64'h0123_4567_89AB_CD00 | 64'(i), 8'hFF);
            step;
        end
        issue(64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
        #2;
        chk("full_ready", 64'(bus.ready), 64'd0);
        step;
        bus.MemWr = 1'b0;
        #2;
        chk("full_ignored_ready", 64'(bus.ready), 64'd0);
        chk("full_ignored_error", 64'(bus.error), 64'd0);
        bus.mem_ack = 1'b1;
        repeat (4) step;
        bus.mem_ack = 1'b0;
        #2;
        chk("full_drain_empty", 64'(bus.empty), 64'd1);
        chk("full_drain_ready", 64'(bus.ready), 64'd1);

        // load hit against a queued sh
        issue(64'h8000_0102, 64'h1234, 3'b001);
        expect_store(64'h8000_0100, 64'h0000_0000_1234_0000, 8'h0C);
        step;
        bus.MemWr   = 1'b0;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 64'h8000_0107;
        #2;
        chk("ldc_hit", 64'(bus.ld_conflict), 64'd1);
        bus.ld_addr = 64'h8000_0108;
        #1;
        chk("ldc_next_word", 64'(bus.ld_conflict), 64'd0);
        bus.ld_addr = 64'h8000_0107;
        bus.ld_en   = 1'b0;
        #1;
        chk("ldc_no_en", 64'(bus.ld_conflict), 64'd0);
        bus.ld_en   = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        chk("ldc_head_acking", 64'(bus.ld_conflict), 64'd1);
        step;
        bus.mem_ack = 1'b0;
        #2;
        chk("ldc_after_pop", 64'(bus.ld_conflict), 64'd0);
        bus.ld_en = 1'b0;

        // full FIFO, store and ack in the same cycle
        for (int i = 0; i < 4; i++) begin
            issue(64'h8000_3000 + 64'(8 * i), 64'hCAFE_0000_0000_0000 | 64'(i), 3'b011);
            expect_store(64'h8000_3000 + 64'(8 * i), 64'hCAFE_0000_0000_0000 | 64'(i), 8'hFF);
            step;
        end
        issue(64'h8000_3020, 64'hCAFE_0000_0000_0004, 3'b011);
        expect_store(64'h8000_3020, 64'hCAFE_0000_0000_0004, 8'hFF);
        bus.mem_ack = 1'b1;
        #2;
        chk("swap_full_ready", 64'(bus.ready), 64'd0);
        step;
        bus.mem_ack = 1'b0;
        #2;
        chk("swap_pop_only", 64'(bus.ready), 64'd1);
        step;
        bus.MemWr = 1'b0;
        #2;
        chk("swap_accepted", 64'(bus.ready), 64'd0);
        bus.mem_ack = 1'b1;
        repeat (4) step;
        bus.mem_ack = 1'b0;
        #2;
        chk("swap_drain_empty", 64'(bus.empty), 64'd1);

        // reset discards queued stores
        issue(64'h8000_5000, 64'h1111_1111_1111_1111, 3'b011);
        step;
        issue(64'h8000_5008, 64'h2222_2222_2222_2222, 3'b011);
        step;
        bus.MemWr = 1'b0;
        #2;
        chk("prerst_valid", 64'(bus.mem_valid), 64'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        #2;
        chk("postrst_valid", 64'(bus.mem_valid), 64'd0);
        chk("postrst_empty", 64'(bus.empty), 64'd1);
        chk("postrst_ready", 64'(bus.ready), 64'd1);
        bus.mem_ack = 1'b1;
        repeat (2) step;
        bus.mem_ack = 1'b0;
        issue(64'h8000_4003, 64'h5A, 3'b000);
        expect_store(64'h8000_4000, 64'h0000_0000_5A00_0000, 8'h08);
        step;
        bus.MemWr   = 1'b0;
        bus.mem_ack = 1'b1;
        step;
        bus.mem_ack = 1'b0;
        #2;
        chk("postrst_drain_empty", 64'(bus.empty), 64'd1);

        step;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
